uart_8n1_core: RTL and testbench

- Byte-wide 8N1 UART serial engine used as the console peripheral of the RISC-V SoC top.
- The bus-side decoder fires a one-cycle write strobe with a byte; the block serialises it onto the TX pin and reports busy/done.
- An optional receiver deserialises the RX pin into bytes with a valid pulse.
- Bit timing is a fixed integer clock divider; no runtime configuration registers.

---
 rtl/uart_8n1_core_if.sv | 29 ++
 rtl/uart_8n1_core.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_8n1_core.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_8n1_core_if.sv
// +---------------------------------------------------------------------------+
// | uart_8n1_core_if : bus-side strobe/byte handshake plus the serial pins    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface uart_8n1_core_if;
  logic [7:0] ser_tx;
  logic       ser_tx_we;
  logic       ser_tx_busy;
  logic       ser_tx_done;
  logic       uart_tx;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (
    output ser_tx, ser_tx_we, uart_rx,
    input  ser_tx_busy, ser_tx_done, uart_tx, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  ser_tx, ser_tx_we, uart_rx,
    output ser_tx_busy, ser_tx_done, uart_tx, rx_data, rx_valid, rx_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_8n1_core.sv
// +---------------------------------------------------------------------------+
// | uart_8n1_core : 8N1 UART engine, fixed CLK_DIV clocks per bit.            |
// | Receiver built only when UART_RX_EN is defined. Revision: 1.0             |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_8n1_core #(
  parameter int CLK_DIV = 434
) (
  input  wire logic       clk,
  input  wire logic       reset,
  uart_8n1_core_if.slave  bus
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          tx_state, tx_state_d;
  logic [CW-1:0]   tx_cnt, tx_cnt_d;
  logic [2:0]      tx_bit, tx_bit_d;
  logic [7:0]      tx_sh, tx_sh_d;
  logic            tx_line, tx_line_d;
  logic            busy, busy_d;
  logic            done, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_line  <= tx_line_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next values are computed here and registered above, so every pin is a flop.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_line_d  = tx_line;
    busy_d     = busy;
    done_d     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_line_d = 1'b1;
        busy_d    = 1'b0;
        if (bus.ser_tx_we) begin
          tx_sh_d    = bus.ser_tx;
          tx_cnt_d   = DIV_LAST;
          tx_line_d  = 1'b0;
          busy_d     = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_d   = DIV_LAST;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_sh[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_d = DIV_LAST;
          if (tx_bit == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d  = tx_bit + 3'd1;
            tx_sh_d   = tx_sh >> 1;
            tx_line_d = tx_sh[1];
          end
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt == '0) begin
          tx_line_d  = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign bus.uart_tx     = tx_line;
  assign bus.ser_tx_busy = busy;
  assign bus.ser_tx_done = done;

`ifdef UART_RX_EN
  logic            rx_s1, rx_s2, rx_s3;
  state_t          rx_state, rx_state_d;
  logic [CW-1:0]   rx_cnt, rx_cnt_d;
  logic [2:0]      rx_bit, rx_bit_d;
  logic [7:0]      rx_sh, rx_sh_d;
  logic [7:0]      rx_byte, rx_byte_d;
  logic            rx_vld, rx_vld_d;
  logic            rx_er, rx_er_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_vld   <= 1'b0;
      rx_er    <= 1'b0;
    end else begin
      rx_s1    <= bus.uart_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_byte  <= rx_byte_d;
      rx_vld   <= rx_vld_d;
      rx_er    <= rx_er_d;
    end
  end

  // After a framing error the line must rise before the next falling edge,
  // which the edge detector in IDLE already enforces.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_byte_d  = rx_byte;
    rx_vld_d   = 1'b0;
    rx_er_d    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == '0) begin
          if (rx_s2) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_cnt_d   = DIV_LAST;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_d  = {rx_s2, rx_sh[7:1]};
          rx_cnt_d = DIV_LAST;
          if (rx_bit == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_d = S_IDLE;
          if (rx_s2) begin
            rx_byte_d = rx_sh;
            rx_vld_d  = 1'b1;
          end else begin
            rx_er_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data  = rx_byte;
  assign bus.rx_valid = rx_vld;
  assign bus.rx_err   = rx_er;
`else
  logic unused_rx;
  assign unused_rx    = bus.uart_rx;
  assign bus.rx_data  = 8'h00;
  assign bus.rx_valid = 1'b0;
  assign bus.rx_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_8n1_core.sv
// +---------------------------------------------------------------------------+
// | tb_uart_8n1_core : directed bench, CLK_DIV=4 TX instance and CLK_DIV=8    |
// | loopback/RX instance. Revision: 1.0                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_uart_8n1_core;

`ifdef UART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loop_en = 1'b0;
  logic rx_drv = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   vld_n = 0;
  int   err_n = 0;
  logic [7:0] last_rx = 8'h00;

  uart_8n1_core_if bus4();
  uart_8n1_core_if bus8();

  assign bus4.uart_rx = 1'b1;
  assign bus8.uart_rx = loop_en ? bus8.uart_tx : rx_drv;

  uart_8n1_core #(.CLK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  uart_8n1_core #(.CLK_DIV(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_write(input logic [7:0] b);
    bus4.ser_tx    = b;
    bus4.ser_tx_we = 1'b1;
    tick();
    bus4.ser_tx_we = 1'b0;
    bus4.ser_tx    = ~b;
  endtask

  // pat[k] is the k-th transmitted bit (start, d0..d7, stop).
  task automatic watch_frame(input logic [9:0] pat, input int inj, input bit chain,
                             input logic [7:0] nxt);
    int busy_n;
    int done_n;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      check($sformatf("tx_c%0d_bit%0d", i, i / 4), 32'(bus4.uart_tx), 32'(pat[i / 4]));
      busy_n += 32'(bus4.ser_tx_busy);
      done_n += 32'(bus4.ser_tx_done);
      if (i == inj) begin
        bus4.ser_tx    = 8'hFF;
        bus4.ser_tx_we = 1'b1;
      end
      tick();
      bus4.ser_tx_we = 1'b0;
    end
    check("busy_cycles", 32'(busy_n), 32'd40);
    check("done_in_frame", 32'(done_n), 32'd0);
    check("done_pulse", 32'(bus4.ser_tx_done), 32'd1);
    check("busy_after", 32'(bus4.ser_tx_busy), 32'd0);
    check("tx_after", 32'(bus4.uart_tx), 32'd1);
    if (chain) begin
      bus4.ser_tx    = nxt;
      bus4.ser_tx_we = 1'b1;
      tick();
      bus4.ser_tx_we = 1'b0;
    end else begin
      tick();
      check("done_single", 32'(bus4.ser_tx_done), 32'd0);
    end
  endtask

  task automatic rx_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      vld_n += 32'(bus8.rx_valid);
      err_n += 32'(bus8.rx_err);
      if (bus8.rx_valid) last_rx = bus8.rx_data;
      tick();
    end
  endtask

  task automatic drive_frame8(input logic [9:0] pat);
    for (int k = 0; k < 10; k++) begin
      rx_drv = pat[k];
      rx_cycles(8);
    end
  endtask

  initial begin
    int d_n;
    bus4.ser_tx = 8'h00; bus4.ser_tx_we = 1'b0;
    bus8.ser_tx = 8'h00; bus8.ser_tx_we = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_tx", 32'(bus4.uart_tx), 32'd1);
    check("rst_busy", 32'(bus4.ser_tx_busy), 32'd0);
    check("rst_done", 32'(bus4.ser_tx_done), 32'd0);
    check("rst_rx_valid", 32'(bus8.rx_valid), 32'd0);
    check("rst_rx_err", 32'(bus8.rx_err), 32'd0);
    check("rst_rx_data", 32'(bus8.rx_data), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    start_write(8'hA5);
    watch_frame(10'b1101001010, -1, 1'b0, 8'h00);

    // 0x55 with an ignored 0xFF strobe, then 0x00 chained on the done cycle
    start_write(8'h55);
    watch_frame(10'b1010101010, 10, 1'b1, 8'h00);
    watch_frame(10'b1000000000, -1, 1'b0, 8'h00);

    // Reset at the first cycle of bit 3
    start_write(8'hC3);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    check("midrst_tx", 32'(bus4.uart_tx), 32'd1);
    check("midrst_busy", 32'(bus4.ser_tx_busy), 32'd0);
    check("midrst_done", 32'(bus4.ser_tx_done), 32'd0);
    reset = 1'b0;
    d_n = 0;
    for (int i = 0; i < 8; i++) begin
      d_n += 32'(bus4.ser_tx_done);
      tick();
    end
    check("midrst_no_done", 32'(d_n), 32'd0);
    check("midrst_idle_tx", 32'(bus4.uart_tx), 32'd1);
    // 0x96 -> pattern {1, 1001_0110, 0}
    start_write(8'h96);
    watch_frame(10'b1100101100, -1, 1'b0, 8'h00);

    // Loopback of 0x3C on the CLK_DIV=8 instance
    loop_en = 1'b1;
    vld_n = 0; err_n = 0;
    bus8.ser_tx    = 8'h3C;
    bus8.ser_tx_we = 1'b1;
    tick();
    bus8.ser_tx_we = 1'b0;
    bus8.ser_tx    = 8'h00;
    rx_cycles(200);
    check("loop_valid_n", 32'(vld_n), 32'(RX_EN));
    check("loop_err_n", 32'(err_n), 32'd0);
    check("loop_data", 32'(bus8.rx_data), RX_EN ? 32'h3C : 32'h00);
    check("loop_tx_idle", 32'(bus8.ser_tx_busy), 32'd0);

    // Two-cycle low glitch
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (6) tick();
    vld_n = 0; err_n = 0;
    rx_drv = 1'b0;
    rx_cycles(2);
    rx_drv = 1'b1;
    rx_cycles(100);
    check("glitch_valid_n", 32'(vld_n), 32'd0);
    check("glitch_err_n", 32'(err_n), 32'd0);

    // 0x81 with a low stop bit, line held low a further bit time
    vld_n = 0; err_n = 0;
    drive_frame8({1'b0, 8'h81, 1'b0});
    rx_drv = 1'b0;
    rx_cycles(8);
    rx_drv = 1'b1;
    rx_cycles(60);
    check("frm_err_n", 32'(err_n), 32'(RX_EN));
    check("frm_valid_n", 32'(vld_n), 32'd0);
    check("frm_data_kept", 32'(bus8.rx_data), RX_EN ? 32'h3C : 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
